// File: rtl/fp8_add_arbiter_if.sv
// Bus bundle for fp8_add_arbiter: two request channels, the shared adder port
// and the tagged response channel.
interface fp8_add_arbiter_if;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic       add_en_o;
  logic [7:0] add_a_o, add_b_o;
  logic [7:0] add_sum_i;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_sum;
  logic [1:0] rsp_exc;

  // slave: the arbiter itself
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  add_sum_i, rsp_ready,
    output req0_ready, req1_ready, add_en_o, add_a_o, add_b_o,
    output rsp_valid, rsp_id, rsp_sum, rsp_exc
  );

  // master: clients plus the adder datapath
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output add_sum_i, rsp_ready,
    input  req0_ready, req1_ready, add_en_o, add_a_o, add_b_o,
    input  rsp_valid, rsp_id, rsp_sum, rsp_exc
  );
endinterface

// File: rtl/fp8_add_arbiter.sv
// Round-robin sequencer sharing one registered FP8 adder between two clients.
// Optional FP8_ARB_EXC_FLAGS_EN builds NaN/Inf flag registers on rsp_exc.
module fp8_add_arbiter #(
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fp8_add_arbiter_if.slave bus
);

  if (ADD_LAT < 1 || ADD_LAT > 4) begin : g_bad_lat
    $error("fp8_add_arbiter: ADD_LAT must be in 1..4");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] LAT3 = 3'(ADD_LAT);

  typedef struct packed {
    logic       id;
    logic [7:0] sum;
  } rsp_t;

  logic [1:0] state;
  logic [7:0] op_a, op_b;
  logic       last_grant;
  logic [2:0] cnt;
  rsp_t       rsp_q;
  logic       gnt_v, gnt_id, accept, capture;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    gnt_v  = bus.req0_valid | bus.req1_valid;
    gnt_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_grant;
  end

  assign accept         = (state == IDLE) && gnt_v;
  assign capture        = (state == EXEC) && (cnt == 3'd0);
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept &&  gnt_id;

  assign bus.add_en_o = (state == EXEC);
  assign bus.add_a_o  = (state == EXEC) ? op_a : 8'h00;
  assign bus.add_b_o  = (state == EXEC) ? op_b : 8'h00;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_sum   = rsp_q.sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= 8'h00;
      op_b       <= 8'h00;
      last_grant <= 1'b1;
      cnt        <= 3'd0;
      rsp_q      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a       <= gnt_id ? bus.req1_a : bus.req0_a;
          op_b       <= gnt_id ? bus.req1_b : bus.req0_b;
          rsp_q.id   <= gnt_id;
          last_grant <= gnt_id;
          cnt        <= LAT3;
          state      <= EXEC;
        end
        EXEC: if (capture) begin
          rsp_q.sum <= bus.add_sum_i;
          state     <= RESP;
        end else begin
          cnt <= cnt - 3'd1;
        end
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP8_ARB_EXC_FLAGS_EN
  // [1] NaN: all-ones exponent with nonzero mantissa; [0] infinity of either sign
  logic [1:0] exc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_q <= 2'b00;
    end else if (capture) begin
      exc_q <= {(bus.add_sum_i[6:3] == 4'hF) && (bus.add_sum_i[2:0] != 3'd0),
                (bus.add_sum_i[6:0] == 7'h78)};
    end
  end
  assign bus.rsp_exc = exc_q;
`else
  assign bus.rsp_exc = 2'b00;
`endif

endmodule

// File: doc/fp8_add_arbiter.md
# fp8_add_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit floating-point adder (sign/4-bit exponent/3-bit mantissa format) between two requesters. It accepts operand pairs over valid/ready handshakes and drives the adder's operand and enable inputs. It waits a fixed adder latency, captures the sum, and returns it on a tagged valid/ready response channel. It sits between the adder datapath and any two clients, such as a host shift-in port and an on-chip accumulator. Exactly one operation is in flight at a time.

## Interface
- ADD_LAT, 1, cycles from operands stable on add_a_o/add_b_o to a valid add_sum_i; legal range 1..4.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous and active-low.
- req0_valid / req1_valid  in  1  requester has an operand pair.
- req0_ready / req1_ready  out  1  pair accepted this cycle when ready and valid are both high.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- add_en_o  out  1  adder enable; high only while an operation is executing.
- add_a_o, add_b_o  out  8  adder operands.
- add_sum_i  in  8  registered adder result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index of the response.
- rsp_sum  out  8  captured sum.
- rsp_exc  out  2  bit [1] is a NaN result, bit [0] is an infinity result (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Arbitrate. If only one valid is high, grant that requester. If both are high, grant the requester that is not last_grant.
  - The ready of the granted requester is high combinationally, and only in IDLE. The other ready is low.
  - On handshake: latch both operands into op_a/op_b, latch id, set last_grant = id, load cnt = ADD_LAT, go to EXEC.
- EXEC
  - add_en_o = 1; add_a_o = op_a; add_b_o = op_b, held constant.
  - cnt decrements each cycle.
  - In the cycle with cnt == 0: capture add_sum_i into rsp_sum, compute rsp_exc, go to RESP.
- RESP
  - rsp_valid = 1. rsp_id, rsp_sum and rsp_exc are stable until the handshake.
  - On rsp_valid && rsp_ready, return to IDLE.
  - Both req readies stay low; requests are never accepted while a response is pending.
- Outside EXEC, add_en_o = 0 and add_a_o = add_b_o = 8'h00.
- Operands and results pass through bit-exact. The block does not inspect or modify FP fields, except for rsp_exc.
- last_grant resets to 1, so req0 wins the first contention.
- If a requester drops valid without a handshake, it loses nothing and the arbiter state is unchanged.
- cnt is 3 bits. ADD_LAT outside 1..4 is a configuration error and must be caught by an elaboration-time check.

## Timing
- Request handshake in cycle T → operands driven on cycles T+1 .. T+1+ADD_LAT → sum captured at the end of cycle T+1+ADD_LAT → rsp_valid high from cycle T+2+ADD_LAT (T+3 for ADD_LAT=1).
- Response handshake in cycle R → IDLE in R+1 → next request can be accepted in R+1.
- Peak throughput is one operation per ADD_LAT+3 cycles when rsp_ready is held high.
- Reset values (cycle after rst_n sampled low): state IDLE, all readies 0, add_en_o 0, add_a_o/add_b_o 8'h00, rsp_valid 0, rsp_id 0, rsp_sum 8'h00, rsp_exc 2'b00, last_grant 1, cnt 0.
- Reset during EXEC or RESP discards the operation. No response is produced and the adder is disabled from the next cycle.

## Configuration
- FP8_ARB_EXC_FLAGS_EN defined:
  - rsp_exc[1] = (sum[6:3] == 4'hF && sum[2:0] != 0).
  - rsp_exc[0] = (sum[6:0] == 7'h78).
  - Both are registered at capture together with rsp_sum.
- FP8_ARB_EXC_FLAGS_EN undefined: rsp_exc is tied to 2'b00 and no flag registers are built. Port list is unchanged.

## Test plan
All scenarios use a bench adder model with ADD_LAT=1.
- Single request: req0 a=8'h38, b=8'h38, rsp_ready=1 → req0_ready high in the accept cycle; add_en_o high for exactly 2 cycles; rsp_valid 3 cycles after the handshake with rsp_sum=8'h40, rsp_id=0, rsp_exc=00.
- Contention: req0 and req1 valid continuously with distinct operands → grants alternate 0,1,0,1 starting with 0; each rsp_id matches the source operands.
- Backpressure: rsp_ready low for 5 cycles during RESP → rsp_valid held with rsp_sum stable, both readies low; after rsp_ready rises, next acceptance occurs the following cycle.
- Exceptions (macro defined): operands 8'h78 + 8'h08 → rsp_sum=8'h78, rsp_exc=01. Operands 8'h79 + 8'h10 → rsp_sum=8'h7F, rsp_exc=10. With the macro undefined, the same stimuli give rsp_exc=00.
- Reset mid-op: assert rst_n low in the EXEC cycle → next cycle add_en_o=0 and rsp_valid=0; no response ever appears; the first request after reset is accepted, and req0 wins contention.
- Sweep ADD_LAT=1..4 → rsp_valid appears exactly ADD_LAT+2 cycles after the request handshake.
